// File: rtl/alu_serial_pkg.sv
// Shared types and constants for the bit-serial ALU issue path.
// Holds the 4-bit ALU op encoding ({sub_sra, func3}) and the issue FSM state type.
package alu_serial_pkg;

   typedef logic [3:0] alu_op_t;

   localparam alu_op_t ALU_ADD  = 4'b0000;
   localparam alu_op_t ALU_SUB  = 4'b1000;
   localparam alu_op_t ALU_SLL  = 4'b0001;
   localparam alu_op_t ALU_SLT  = 4'b0010;
   localparam alu_op_t ALU_SLTU = 4'b0011;
   localparam alu_op_t ALU_XOR  = 4'b0100;
   localparam alu_op_t ALU_SRL  = 4'b0101;
   localparam alu_op_t ALU_SRA  = 4'b1101;
   localparam alu_op_t ALU_OR   = 4'b0110;
   localparam alu_op_t ALU_AND  = 4'b0111;

   typedef enum logic [2:0] {
      FLUSH = 3'd0,
      IDLE  = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      HOLD  = 3'd4
   } issue_state_t;

   // Longest start-to-done time of the serial ALU, in cycles.
   localparam int ALU_MAX_LATENCY = 63;

endpackage

// File: rtl/alu_serial_issue_op_decode.sv
// alu_op_decode: RISC-V func3/func7 -> serial ALU op.
// Only func7[5] carries meaning; for OP-IMM it is honoured only on the shift-right
// encoding, so an ADDI with a negative immediate never turns into SUB.
module alu_op_decode
   import alu_serial_pkg::*;
(
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   input  logic       is_imm,
   output alu_op_t    op
);

   logic sub_sra;
   logic func7_unused;

   // The remaining func7 bits are immediate payload for I-type and do not affect the op.
   assign func7_unused = ^{func7[6], func7[4:0]};

   // Select the sub/arith-shift bit and concatenate with func3.
   always_comb begin
      sub_sra = 1'b0;
      if (is_imm) begin
         sub_sra = (func3 == 3'b101) & func7[5];
      end else begin
         sub_sra = func7[5];
      end
      op = {sub_sra, func3};
   end

endmodule

// File: rtl/alu_serial_issue.sv
// alu_serial_issue: initiator side of the bit-serial ALU start/done interface.
// One operation in flight: accept on in_valid/in_ready, pulse alu_start for one
// cycle, hold operands until alu_done, then present the result on out_valid/out_ready.
// Handshakes: a transfer happens on a posedge where valid & ready are both high;
// valid, once raised, holds its payload stable until that transfer.
// Optional watchdog on the WAIT state is enabled by defining ALU_SERIAL_WDT_EN.
module alu_serial_issue
   import alu_serial_pkg::*;
#(
   parameter int TAG_W        = 5,
   parameter int FLUSH_CYCLES = 64,
   parameter int WDT_CYCLES   = 80
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_a,
   input  logic [31:0]       in_b,
   input  logic [2:0]        in_func3,
   input  logic [6:0]        in_func7,
   input  logic              in_is_imm,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_result,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_err,
   output logic [31:0]       alu_rs1,
   output logic [31:0]       alu_rs2,
   output alu_op_t           alu_op,
   output logic              alu_start,
   input  logic              alu_done,
   input  logic [31:0]       alu_rd,
   output logic              busy,
   output issue_state_t      dbg_state
);

   // One counter serves both the post-reset flush and the watchdog.
   localparam int CNT_MAX = (FLUSH_CYCLES > WDT_CYCLES) ? FLUSH_CYCLES : WDT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
`ifdef ALU_SERIAL_WDT_EN
   localparam logic [CNT_W-1:0] WDT_LAST   = CNT_W'(WDT_CYCLES - 1);
`endif

   // The flush window must outlast any operation an un-reset ALU may still be running.
   generate
      if (FLUSH_CYCLES <= ALU_MAX_LATENCY) begin : g_flush_too_short
         $error("FLUSH_CYCLES must exceed ALU_MAX_LATENCY");
      end
   endgenerate

   issue_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      rs1_q, rs1_d;
   logic [31:0]      rs2_q, rs2_d;
   alu_op_t          op_q, op_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [31:0]      result_q, result_d;
`ifdef ALU_SERIAL_WDT_EN
   logic             err_q, err_d;
   logic             wdt_expire;
`endif
   alu_op_t          dec_op;

   alu_op_decode u_decode (
      .func3  (in_func3),
      .func7  (in_func7),
      .is_imm (in_is_imm),
      .op     (dec_op)
   );

`ifdef ALU_SERIAL_WDT_EN
   assign wdt_expire = (state_q == WAIT) && !alu_done && (cnt_q == WDT_LAST);
`endif

   // State and datapath registers; reset lands in FLUSH with everything cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FLUSH;
         cnt_q    <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         op_q     <= ALU_ADD;
         tag_q    <= '0;
         result_q <= '0;
`ifdef ALU_SERIAL_WDT_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         op_q     <= op_d;
         tag_q    <= tag_d;
         result_q <= result_d;
`ifdef ALU_SERIAL_WDT_EN
         err_q    <= err_d;
`endif
      end
   end

   // Next-state logic; alu_done outside WAIT is deliberately ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FLUSH: if (cnt_q == FLUSH_LAST) state_d = IDLE;
         IDLE:  if (in_valid) state_d = ISSUE;
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (alu_done) state_d = HOLD;
`ifdef ALU_SERIAL_WDT_EN
            else if (wdt_expire) state_d = HOLD;
`endif
         end
         HOLD: begin
            if (out_ready) begin
`ifdef ALU_SERIAL_WDT_EN
               // A timed-out ALU may still be busy, so drain it before reuse.
               state_d = err_q ? FLUSH : IDLE;
`else
               state_d = IDLE;
`endif
            end
         end
         default: state_d = FLUSH;
      endcase
   end

   // Counter, operand latch and result capture.
   always_comb begin
      cnt_d    = '0;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      op_d     = op_q;
      tag_d    = tag_q;
      result_d = result_q;
`ifdef ALU_SERIAL_WDT_EN
      err_d    = err_q;
`endif
      case (state_q)
         FLUSH: cnt_d = cnt_q + CNT_W'(1);
         IDLE: begin
            if (in_valid) begin
               rs1_d = in_a;
               rs2_d = in_b;
               op_d  = dec_op;
               tag_d = in_tag;
            end
         end
         WAIT: begin
`ifdef ALU_SERIAL_WDT_EN
            cnt_d = cnt_q + CNT_W'(1);
`endif
            if (alu_done) begin
               result_d = alu_rd;
            end
`ifdef ALU_SERIAL_WDT_EN
            else if (wdt_expire) begin
               result_d = '0;
               err_d    = 1'b1;
            end
`endif
         end
         HOLD: begin
`ifdef ALU_SERIAL_WDT_EN
            if (out_ready) err_d = 1'b0;
`endif
         end
         default: ;
      endcase
   end

   // Outputs decoded from state; all forced to zero while rst is high.
   always_comb begin
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      alu_start  = 1'b0;
      busy       = 1'b1;
      alu_rs1    = '0;
      alu_rs2    = '0;
      alu_op     = ALU_ADD;
      out_result = '0;
      out_tag    = '0;
      out_err    = 1'b0;
      if (!rst) begin
         in_ready   = (state_q == IDLE);
         out_valid  = (state_q == HOLD);
         alu_start  = (state_q == ISSUE);
         busy       = (state_q != IDLE);
         alu_rs1    = rs1_q;
         alu_rs2    = rs2_q;
         alu_op     = op_q;
         out_result = result_q;
         out_tag    = tag_q;
`ifdef ALU_SERIAL_WDT_EN
         out_err    = err_q;
`endif
      end
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_serial_issue.sv
// Directed bench for alu_serial_issue with a behavioural serial-ALU model.
// Build with ALU_SERIAL_WDT_EN defined to add the watchdog scenario.
module tb_alu_serial_issue;
   import alu_serial_pkg::*;

   localparam int TAG_W = 5;
   localparam int FLUSH_CYCLES = 64;
   localparam int WDT_CYCLES = 80;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [31:0]       in_a = '0;
   logic [31:0]       in_b = '0;
   logic [2:0]        in_func3 = '0;
   logic [6:0]        in_func7 = '0;
   logic              in_is_imm = 1'b0;
   logic [TAG_W-1:0]  in_tag = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [31:0]       out_result;
   logic [TAG_W-1:0]  out_tag;
   logic              out_err;
   logic [31:0]       alu_rs1;
   logic [31:0]       alu_rs2;
   alu_op_t           alu_op;
   logic              alu_start;
   logic              alu_done = 1'b0;
   logic [31:0]       alu_rd = '0;
   logic              busy;
   issue_state_t      dbg_state;

   int total = 0;
   int bad = 0;

   alu_serial_issue #(
      .TAG_W        (TAG_W),
      .FLUSH_CYCLES (FLUSH_CYCLES),
      .WDT_CYCLES   (WDT_CYCLES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_func3   (in_func3),
      .in_func7   (in_func7),
      .in_is_imm  (in_is_imm),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag),
      .out_err    (out_err),
      .alu_rs1    (alu_rs1),
      .alu_rs2    (alu_rs2),
      .alu_op     (alu_op),
      .alu_start  (alu_start),
      .alu_done   (alu_done),
      .alu_rd     (alu_rd),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: sim time exceeded, expected completion");
      $fatal(1, "timeout");
   end

   // Behavioural serial ALU: latches operands on start, pulses done alu_lat cycles later.
   int          alu_lat = 8;
   bit          alu_hang = 1'b0;
   int          alu_cnt = 0;
   logic [31:0] m_a = '0;
   logic [31:0] m_b = '0;
   alu_op_t     m_op = ALU_ADD;

   function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input alu_op_t op);
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_SLL:  return a << b[4:0];
         ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
         ALU_XOR:  return a ^ b;
         ALU_SRL:  return a >> b[4:0];
         ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
         ALU_OR:   return a | b;
         ALU_AND:  return a & b;
         default:  return 32'hDEAD_BEEF;
      endcase
   endfunction

   always @(posedge clk) begin
      #2;
      alu_done = 1'b0;
      if (alu_start === 1'b1) begin
         alu_cnt = alu_lat;
         m_a = alu_rs1;
         m_b = alu_rs2;
         m_op = alu_op;
      end else if (alu_cnt > 0) begin
         alu_cnt--;
         if (alu_cnt == 0 && !alu_hang) begin
            alu_done = 1'b1;
            alu_rd = alu_model(m_a, m_b, m_op);
         end
      end
   end

   // done must never coincide with start
   always @(negedge clk) begin
      if (alu_start === 1'b1 && alu_done === 1'b1) begin
         bad++;
         $display("FAIL done_in_issue: alu_done=1 while alu_start=1, required 0");
      end
   end

   // driver tasks (all start and end on a negedge)
   task automatic issue_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                            input logic [6:0] f7, input logic imm, input logic [TAG_W-1:0] tag,
                            output bit ok);
      int n = 0;
      in_valid = 1'b1; in_a = a; in_b = b; in_func3 = f3; in_func7 = f7;
      in_is_imm = imm; in_tag = tag;
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      ok = (in_ready === 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cycles, output bit ok, output bit done_prev);
      logic prev = 1'b0;
      cycles = 0;
      while (out_valid !== 1'b1 && cycles < 300) begin
         prev = alu_done;
         @(negedge clk);
         cycles++;
      end
      ok = (out_valid === 1'b1);
      done_prev = prev;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      int early = 0;
      #1;
      total++;
      if ({in_ready, out_valid, alu_start, alu_op, alu_rs1, alu_rs2, out_result, out_tag, out_err} !== '0) begin
         bad++;
         $display("FAIL rst_outputs: got in_ready=%b out_valid=%b start=%b op=%h, required all 0",
                  in_ready, out_valid, alu_start, alu_op);
      end
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy: got %b required 1", busy); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      total++;
      if (dbg_state !== FLUSH) begin bad++; $display("FAIL rst_state: got %0d required FLUSH", dbg_state); end
      for (int i = 0; i < FLUSH_CYCLES; i++) begin
         if (in_ready !== 1'b0) early++;
         @(negedge clk);
      end
      total++;
      if (early != 0) begin bad++; $display("FAIL flush_ready_low: in_ready high %0d times, required 0", early); end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_end: in_ready=%b required 1", in_ready); end
   endtask

   task automatic test_add();
      bit ok;
      int n = 0;
      int unstable = 0;
      logic prev = 1'b0;
      issue_req(32'd5, 32'd7, 3'b000, 7'h00, 1'b0, 5'd3, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL add_accept: not accepted within bound"); end
      total++;
      if ({alu_start, alu_op, alu_rs1, alu_rs2, in_ready, busy} !== {1'b1, ALU_ADD, 32'd5, 32'd7, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL add_issue: start=%b op=%h rs1=%h rs2=%h in_ready=%b busy=%b, required 1 0 5 7 0 1",
                  alu_start, alu_op, alu_rs1, alu_rs2, in_ready, busy);
      end
      @(negedge clk);
      total++;
      if (alu_start !== 1'b0) begin bad++; $display("FAIL add_start_once: start=%b required 0", alu_start); end
      while (out_valid !== 1'b1 && n < 300) begin
         if (alu_rs1 !== 32'd5 || alu_rs2 !== 32'd7 || alu_op !== ALU_ADD || alu_start !== 1'b0) unstable++;
         prev = alu_done;
         @(negedge clk);
         n++;
      end
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL add_timeout: out_valid=%b required 1", out_valid); end
      total++;
      if (unstable != 0) begin bad++; $display("FAIL add_operand_hold: %0d unstable cycles, required 0", unstable); end
      total++;
      if (prev !== 1'b1) begin bad++; $display("FAIL add_latency: done not seen in the cycle before out_valid"); end
      total++;
      if ({out_result, out_tag, out_err} !== {32'd12, 5'd3, 1'b0}) begin
         bad++;
         $display("FAIL add_result: result=%h tag=%0d err=%b, required 0000000c 3 0", out_result, out_tag, out_err);
      end
      release_out();
      total++;
      if ({out_valid, in_ready} !== 2'b01) begin
         bad++;
         $display("FAIL add_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_sub();
      bit ok, dp;
      int cyc;
      issue_req(32'd3, 32'd5, 3'b000, 7'h20, 1'b0, 5'd1, ok);
      total++;
      if (alu_op !== ALU_SUB) begin bad++; $display("FAIL sub_op: got %b required 1000", alu_op); end
      wait_out(cyc, ok, dp);
      total++;
      if (!ok || out_result !== 32'hFFFF_FFFE || out_tag !== 5'd1) begin
         bad++;
         $display("FAIL sub_result: ok=%b result=%h tag=%0d, required fffffffe 1", ok, out_result, out_tag);
      end
      release_out();
   endtask

   task automatic test_imm();
      bit ok, dp;
      int cyc;
      issue_req(32'd10, 32'hFFFF_FFFF, 3'b000, 7'h7F, 1'b1, 5'd2, ok);
      total++;
      if (alu_op !== ALU_ADD) begin bad++; $display("FAIL addi_op: got %b required 0000", alu_op); end
      wait_out(cyc, ok, dp);
      total++;
      if (!ok || out_result !== 32'd9) begin
         bad++;
         $display("FAIL addi_result: ok=%b result=%h, required 00000009", ok, out_result);
      end
      release_out();
      issue_req(32'h8000_0000, 32'd4, 3'b101, 7'h20, 1'b1, 5'd9, ok);
      total++;
      if (alu_op !== ALU_SRA) begin bad++; $display("FAIL srai_op: got %b required 1101", alu_op); end
      wait_out(cyc, ok, dp);
      total++;
      if (!ok || out_result !== 32'hF800_0000 || out_tag !== 5'd9) begin
         bad++;
         $display("FAIL srai_result: ok=%b result=%h tag=%0d, required f8000000 9", ok, out_result, out_tag);
      end
      release_out();
   endtask

   task automatic test_backpressure();
      bit ok, dp;
      int cyc;
      int drift = 0;
      issue_req(32'h0000_1000, 32'h0000_0234, 3'b000, 7'h00, 1'b0, 5'd7, ok);
      wait_out(cyc, ok, dp);
      total++;
      if (!ok) begin bad++; $display("FAIL bp_timeout: out_valid never rose"); end
      in_valid = 1'b1; in_a = 32'd99; in_b = 32'd1; in_func3 = 3'b000; in_func7 = 7'h00;
      in_is_imm = 1'b0; in_tag = 5'd12;
      for (int i = 0; i < 5; i++) begin
         if (out_valid !== 1'b1 || out_result !== 32'h1234 || out_tag !== 5'd7 ||
             in_ready !== 1'b0 || alu_start !== 1'b0) drift++;
         @(negedge clk);
      end
      total++;
      if (drift != 0) begin bad++; $display("FAIL bp_hold: %0d bad cycles, required 0", drift); end
      in_valid = 1'b0;
      release_out();
      total++;
      if ({out_valid, in_ready, alu_start} !== 3'b010) begin
         bad++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b start=%b, required 0 1 0",
                  out_valid, in_ready, alu_start);
      end
   endtask

   task automatic test_reset_mid_wait();
      bit ok, dp;
      int cyc;
      int early = 0;
      alu_lat = 20;
      issue_req(32'h8000_0000, 32'd31, 3'b101, 7'h00, 1'b0, 5'd4, ok);
      total++;
      if (alu_op !== ALU_SRL) begin bad++; $display("FAIL srl_op: got %b required 0101", alu_op); end
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if ({in_ready, out_valid, alu_start, alu_op, alu_rs1, alu_rs2, out_result, out_tag, out_err} !== '0 ||
          busy !== 1'b1) begin
         bad++;
         $display("FAIL midrst_outputs: rs1=%h busy=%b, required 0 1", alu_rs1, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < FLUSH_CYCLES; i++) begin
         if (in_ready !== 1'b0 || out_valid !== 1'b0) early++;
         @(negedge clk);
      end
      total++;
      if (early != 0) begin bad++; $display("FAIL midrst_flush: %0d bad cycles, required 0", early); end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: in_ready=%b required 1", in_ready); end
      alu_lat = 8;
      issue_req(32'd1, 32'd1, 3'b000, 7'h00, 1'b0, 5'd5, ok);
      wait_out(cyc, ok, dp);
      total++;
      if (!ok || out_result !== 32'd2 || out_tag !== 5'd5) begin
         bad++;
         $display("FAIL midrst_next: ok=%b result=%h tag=%0d, required 2 5", ok, out_result, out_tag);
      end
      release_out();
   endtask

`ifdef ALU_SERIAL_WDT_EN
   task automatic test_watchdog();
      bit ok, dp;
      int cyc;
      int early = 0;
      alu_hang = 1'b1;
      issue_req(32'd1, 32'd2, 3'b000, 7'h00, 1'b0, 5'd6, ok);
      wait_out(cyc, ok, dp);
      total++;
      if (!ok || cyc != WDT_CYCLES + 1) begin
         bad++;
         $display("FAIL wdt_time: ok=%b cycles=%0d, required %0d", ok, cyc, WDT_CYCLES + 1);
      end
      total++;
      if ({out_err, out_result} !== {1'b1, 32'd0}) begin
         bad++;
         $display("FAIL wdt_result: err=%b result=%h, required 1 0", out_err, out_result);
      end
      release_out();
      for (int i = 0; i < FLUSH_CYCLES; i++) begin
         if (in_ready !== 1'b0) early++;
         @(negedge clk);
      end
      total++;
      if (early != 0) begin bad++; $display("FAIL wdt_flush: in_ready high %0d times, required 0", early); end
      total++;
      if (in_ready !== 1'b1 || out_err !== 1'b0) begin
         bad++;
         $display("FAIL wdt_recover: in_ready=%b err=%b, required 1 0", in_ready, out_err);
      end
      alu_hang = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_imm();
      test_backpressure();
      test_reset_mid_wait();
`ifdef ALU_SERIAL_WDT_EN
      test_watchdog();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_serial_issue.md
Name: alu_serial_issue

Overview:
- Initiator side of the bit-serial ALU start/done interface. It sits in the execute stage between the decode/operand-select logic and the serial ALU.
- Accepts one operation per valid/ready handshake and translates RISC-V func3/func7 into the 4-bit ALU op.
- Drives start, holds operands stable for the whole serial computation, captures the result on done, and presents it downstream with a valid/ready handshake.

Parameters:
- TAG_W, 5, width of the opaque tag carried from request to result (e.g. destination register index).
- FLUSH_CYCLES, 64, idle cycles after reset before the first issue. Must exceed the worst-case ALU latency of 63 cycles.
- WDT_CYCLES, 80, watchdog limit in cycles. Used only with ALU_SERIAL_WDT_EN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_a  in  32  operand A (rs1 value).
- in_b  in  32  operand B (rs2 value or sign-extended immediate; shamt in [4:0] for shifts).
- in_func3  in  3  instruction func3.
- in_func7  in  7  instruction func7 (immediate bits [31:25] for I-type).
- in_is_imm  in  1  1 = OP-IMM instruction, 0 = OP.
- in_tag  in  TAG_W  tag.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_result  out  32  captured ALU result.
- out_tag  out  TAG_W  tag of the result.
- out_err  out  1  watchdog expiry flag; constant 0 without the macro.
- alu_rs1  out  32  to ALU rs1.
- alu_rs2  out  32  to ALU rs2.
- alu_op  out  4  to ALU op.
- alu_start  out  1  to ALU start.
- alu_done  in  1  from ALU done (one-cycle pulse).
- alu_rd  in  32  from ALU rd.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: one clock, synchronous active-high (clk/rst). While rst is high, every output is 0 (in_ready=0, out_valid=0, alu_start=0, alu_op=0, alu_rs1=0, alu_rs2=0, out_result=0, out_tag=0, out_err=0, busy=1) and the state becomes FLUSH with the counter cleared.
- Op decode: alu_op = {sub_sra, func3}.
  - For OP: sub_sra = func7[5].
  - For OP-IMM: sub_sra = func7[5] only when func3 = 3'b101; otherwise 0. So ADDI with a negative immediate never becomes SUB.
- FLUSH: in_ready=0. Counts FLUSH_CYCLES cycles, then goes to IDLE. This lets an ALU that has no reset drain any operation in flight. alu_done pulses are ignored.
- IDLE: in_ready=1. On handshake, latch in_a, in_b, decoded op and in_tag into the alu_* / tag registers; next state ISSUE. Any alu_done seen here is ignored.
- ISSUE: exactly one cycle with alu_start=1; next state WAIT.
- WAIT: alu_start=0.
  - alu_rs1, alu_rs2 and alu_op stay constant from ISSUE until done; the ALU reads operands bit-serially throughout.
  - At the posedge where alu_done=1: out_result <= alu_rd, out_valid <= 1, next state HOLD.
- HOLD: out_valid=1. out_result and out_tag stay stable until out_ready. On handshake: out_valid <= 0, out_err <= 0, next state IDLE.
- Latency: accept at edge N, start high in cycle N+1. Result visible 1 cycle after done, i.e. (ALU latency + 2) cycles after accept.
- Single outstanding operation; in_ready is 0 in ISSUE, WAIT and HOLD.
- Reset during WAIT or HOLD: the operation is discarded, no out_valid is raised, and the block enters FLUSH.
- alu_done asserted during ISSUE: illegal; the bench asserts it never occurs.

Optional Feature:
- Macro ALU_SERIAL_WDT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - If it reaches WDT_CYCLES without alu_done: out_result=0, out_err=1, out_valid=1, state HOLD.
  - HOLD handshake then goes to FLUSH instead of IDLE, so the ALU is drained before the next issue.
- Undefined: no counter; WAIT lasts indefinitely; out_err is tied to 0.

Decomposition:
- Package alu_serial_pkg:
  - alu_op_t as logic [3:0], with constants ALU_ADD=0000, ALU_SUB=1000, ALU_SLL=0001, ALU_SLT=0010, ALU_SLTU=0011, ALU_XOR=0100, ALU_SRL=0101, ALU_SRA=1101, ALU_OR=0110, ALU_AND=0111.
  - issue_state_t enum: FLUSH, IDLE, ISSUE, WAIT, HOLD.
  - ALU_MAX_LATENCY = 63.
- One combinational sub-module alu_op_decode (func3, func7, is_imm -> alu_op_t), shared with later decode logic.

Test Plan:
- ADD: OP, func3=000, func7=0x00, a=5, b=7 -> alu_op=0000, out_result=12; start high for exactly one cycle.
- SUB: OP, func3=000, func7=0x20, a=3, b=5 -> alu_op=1000, out_result=0xFFFFFFFE.
- ADDI and SRAI:
  - ADDI: OP-IMM, func3=000, func7=0x7F, a=10, b=0xFFFFFFFF -> alu_op=0000, out_result=9.
  - SRAI: OP-IMM, func3=101, func7=0x20, a=0x80000000, b=4 -> alu_op=1101, out_result=0xF8000000.
- Backpressure: out_ready held low 5 cycles after a result of 0x1234 with tag 7 -> out_valid, out_result and out_tag stay stable, in_ready=0; a request offered during this time is not accepted.
- Reset mid-WAIT: rst pulsed 1 cycle during a SRL by 31 -> no out_valid; in_ready=0 for 64 cycles; the next ADD 1+1 returns 2.
- With ALU_SERIAL_WDT_EN: the ALU model never asserts done -> after 80 WAIT cycles out_valid=1, out_err=1, out_result=0; after the handshake the block goes through FLUSH before in_ready rises.
